sm_colour_sensor_scanner: RTL and testbench



---
 rtl/sm_colour_sensor_scanner_if.sv | 29 ++
 rtl/sm_colour_sensor_scanner.sv | 181 ++++++++++++++++++
 tb/tb_sm_colour_sensor_scanner.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_colour_sensor_scanner_if.sv
// Sensor pin and result bundle between the colour scanner and its host logic.
interface sm_colour_sensor_scanner_if #(
    parameter int unsigned CNT_W = 7
);
    logic             en;
    logic             signal;
    logic             S0;
    logic             S1;
    logic             S2;
    logic             S3;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_b;
    logic [CNT_W-1:0] count_g;
    logic             frame_done;
    logic [2:0]       color;
    logic             color_change;

    // Host / bench side: drives enable and the sensor output, observes results.
    modport master (
        output en, signal,
        input  S0, S1, S2, S3, count_r, count_b, count_g, frame_done, color, color_change
    );

    // Scanner side.
    modport slave (
        input  en, signal,
        output S0, S1, S2, S3, count_r, count_b, count_g, frame_done, color, color_change
    );
endinterface

// File: rtl/sm_colour_sensor_scanner.sv
// TCS3200-style colour sensor scanner: steps red/blue/green filters, counts
// sensor edges per window, classifies each frame and debounces the colour.
module sm_colour_sensor_scanner #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 7,
    parameter int unsigned CONFIRM       = 3,
    parameter logic [1:0]  SCALE         = 2'b01,
    parameter logic [47:0] THR_RED       = {8'h0B, 8'h14, 8'h17, 8'h23, 8'h04, 8'h08},
    parameter logic [47:0] THR_BLUE      = {8'h07, 8'h0A, 8'h13, 8'h1A, 8'h07, 8'h0C},
    parameter logic [47:0] THR_GREEN     = {8'h03, 8'h07, 8'h19, 8'h22, 8'h05, 8'h08}
) (
    input  logic                         clk,
    input  logic                         rst,
    sm_colour_sensor_scanner_if.slave    bus
);

    localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned CONF_W  = $clog2(CONFIRM + 1);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_MAX    = CONF_W'(CONFIRM);
    localparam logic [CNT_W-1:0]  CNT_SAT     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, STORE} state_t;
    typedef enum logic [1:0] {F_RED = 2'b00, F_BLUE = 2'b01, F_GREEN = 2'b11} filter_t;

    state_t            state;
    filter_t           filter;
    logic [1:0]        scale;
    logic [TMR_W-1:0]  tmr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  count_r_q;
    logic [CNT_W-1:0]  count_b_q;
    logic [CNT_W-1:0]  count_g_q;
    logic              frame_done_q;
    logic [2:0]        color_q;
    logic              color_change_q;
    logic [2:0]        prev_cand;
    logic [CONF_W-1:0] conf;
    logic              sync_meta;
    logic              sync_q;
    logic              sync_prev;

    logic              edge_c;
    logic [2:0]        hits_c;
    logic [2:0]        cand_c;
    logic [CONF_W-1:0] conf_next_c;

    // Exclusive window test of one colour's threshold set.
    function automatic logic in_window(input logic [47:0] thr, input logic [7:0] r,
                                       input logic [7:0] b, input logic [7:0] g);
        return (r > thr[47:40]) && (r < thr[39:32]) &&
               (b > thr[31:24]) && (b < thr[23:16]) &&
               (g > thr[15:8])  && (g < thr[7:0]);
    endfunction

    // Edge detect and frame classification; green comes straight from the live counter in STORE.
    always_comb begin
        edge_c = sync_q & ~sync_prev;
        hits_c = {in_window(THR_GREEN, 8'(count_r_q), 8'(count_b_q), 8'(cnt)),
                  in_window(THR_BLUE,  8'(count_r_q), 8'(count_b_q), 8'(cnt)),
                  in_window(THR_RED,   8'(count_r_q), 8'(count_b_q), 8'(cnt))};
        cand_c = $onehot(hits_c) ? hits_c : 3'b000;
        if (cand_c == prev_cand) begin
            conf_next_c = (conf == CONF_MAX) ? conf : CONF_W'(conf + 1'b1);
        end else begin
            conf_next_c = CONF_W'(1);
        end
    end

    // Scan sequencer, edge counter, result registers and colour debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            filter         <= F_RED;
            scale          <= 2'b00;
            tmr            <= '0;
            cnt            <= '0;
            count_r_q      <= '0;
            count_b_q      <= '0;
            count_g_q      <= '0;
            frame_done_q   <= 1'b0;
            color_q        <= 3'b000;
            color_change_q <= 1'b0;
            prev_cand      <= 3'b000;
            conf           <= '0;
            sync_meta      <= 1'b0;
            sync_q         <= 1'b0;
            sync_prev      <= 1'b0;
        end else begin
            frame_done_q   <= 1'b0;
            color_change_q <= 1'b0;
            sync_meta      <= bus.signal;
            sync_q         <= sync_meta;
            sync_prev      <= sync_q;

            if (state != IDLE && !bus.en) begin
                // Abort: drop the partial window and restart debounce; results and colour hold.
                state  <= IDLE;
                filter <= F_RED;
                scale  <= 2'b00;
                tmr    <= '0;
                cnt    <= '0;
                conf   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.en) begin
                            state  <= SETTLE;
                            filter <= F_RED;
                            scale  <= SCALE;
                            tmr    <= '0;
                            cnt    <= '0;
                        end
                    end
                    SETTLE: begin
                        cnt <= '0;
                        if (tmr == SETTLE_LAST) begin
                            tmr   <= '0;
                            state <= COUNT;
                        end else begin
                            tmr <= TMR_W'(tmr + 1'b1);
                        end
                    end
                    COUNT: begin
                        if (edge_c && cnt != CNT_SAT) begin
                            cnt <= CNT_W'(cnt + 1'b1);
                        end
                        if (tmr == WINDOW_LAST) begin
                            tmr   <= '0;
                            state <= STORE;
                        end else begin
                            tmr <= TMR_W'(tmr + 1'b1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        tmr   <= '0;
                        state <= SETTLE;
                        case (filter)
                            F_RED: begin
                                count_r_q <= cnt;
                                filter    <= F_BLUE;
                            end
                            F_BLUE: begin
                                count_b_q <= cnt;
                                filter    <= F_GREEN;
                            end
                            default: begin
                                count_g_q    <= cnt;
                                filter       <= F_RED;
                                frame_done_q <= 1'b1;
                                prev_cand    <= cand_c;
                                conf         <= conf_next_c;
                                if (conf_next_c == CONF_MAX && cand_c != color_q) begin
                                    color_q        <= cand_c;
                                    color_change_q <= 1'b1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.S0           = scale[1];
    assign bus.S1           = scale[0];
    assign bus.S2           = filter[1];
    assign bus.S3           = filter[0];
    assign bus.count_r      = count_r_q;
    assign bus.count_b      = count_b_q;
    assign bus.count_g      = count_g_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.color        = color_q;
    assign bus.color_change = color_change_q;

endmodule

// File: tb/tb_sm_colour_sensor_scanner.sv
// Directed bench for the colour scanner: frame table plus abort, reset,
// saturation and window-boundary sequences.
module tb_sm_colour_sensor_scanner;

    localparam int S   = 16;
    localparam int W   = 1000;
    localparam int PH  = S + W + 1;
    localparam int L   = 3 * PH;
    localparam int S2C = 4;
    localparam int W2C = 200;
    localparam int PH2 = S2C + W2C + 1;
    localparam int L2  = 3 * PH2;

    typedef struct {
        int         nr;
        int         nb;
        int         ng;
        bit         st;
        int         er;
        int         eb;
        int         eg;
        logic [2:0] ecol;
        bit         ecc;
    } row_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    row_t rows [17];

    sm_colour_sensor_scanner_if #(.CNT_W(7)) bus ();
    sm_colour_sensor_scanner_if #(.CNT_W(4)) bus2 ();

    sm_colour_sensor_scanner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sm_colour_sensor_scanner #(
        .WINDOW_CYCLES (W2C),
        .SETTLE_CYCLES (S2C),
        .CNT_W         (4),
        .CONFIRM       (1)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Sensor waveform at phase index j: n edges (period 4) starting 20 cycles
    // into the count window, or two edges early in the settle gap.
    function automatic logic pat(input int j, input int n, input bit st, input int s);
        int k;
        if (st) return (j >= 2 && j < 10 && ((j - 2) % 4) < 2);
        k = j - s - 20;
        return (k >= 0 && k < 4 * n && (k % 4) < 2);
    endfunction

    // One full frame on the main DUT; entered at the negedge of cycle 0 of red settle.
    task automatic run_frame(input int r);
        bit         early;
        bit         pins;
        int         ph;
        int         j;
        int         n;
        logic [1:0] fexp;
        early = 0;
        pins  = 0;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            if (i < L) begin
                ph = i / PH;
                j  = i % PH;
                n  = (ph == 0) ? rows[r].nr : (ph == 1) ? rows[r].nb : rows[r].ng;
                bus.signal = pat(j, n, rows[r].st, S);
                if (bus.frame_done || bus.color_change) early = 1;
                if (j == 5) begin
                    fexp = (ph == 0) ? 2'b00 : (ph == 1) ? 2'b01 : 2'b11;
                    if ({bus.S2, bus.S3} != fexp || {bus.S0, bus.S1} != 2'b01) pins = 1;
                end
            end else begin
                bus.signal = 1'b0;
            end
        end
        chk($sformatf("row%0d early_pulse", r), int'(early), 0);
        chk($sformatf("row%0d pins", r), int'(pins), 0);
        chk($sformatf("row%0d frame_done", r), int'(bus.frame_done), 1);
        chk($sformatf("row%0d count_r", r), int'(bus.count_r), rows[r].er);
        chk($sformatf("row%0d count_b", r), int'(bus.count_b), rows[r].eb);
        chk($sformatf("row%0d count_g", r), int'(bus.count_g), rows[r].eg);
        chk($sformatf("row%0d color", r), int'(bus.color), int'(rows[r].ecol));
        chk($sformatf("row%0d color_change", r), int'(bus.color_change), int'(rows[r].ecc));
    endtask

    initial begin
        bit quiet;
        int ph;
        int j;

        total = 0;
        bad   = 0;

        rows[0]  = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[1]  = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[2]  = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b001, 1'b1};
        rows[3]  = '{8, 24, 10, 1'b0, 8, 24, 10, 3'b001, 1'b0};
        rows[4]  = '{8, 24, 10, 1'b0, 8, 24, 10, 3'b001, 1'b0};
        rows[5]  = '{8, 24, 10, 1'b0, 8, 24, 10, 3'b010, 1'b1};
        rows[6]  = '{0, 0, 0, 1'b0, 0, 0, 0, 3'b010, 1'b0};
        rows[7]  = '{0, 0, 0, 1'b0, 0, 0, 0, 3'b010, 1'b0};
        rows[8]  = '{0, 0, 0, 1'b0, 0, 0, 0, 3'b000, 1'b1};
        rows[9]  = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[10] = '{8, 24, 10, 1'b0, 8, 24, 10, 3'b000, 1'b0};
        rows[11] = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[12] = '{8, 24, 10, 1'b0, 8, 24, 10, 3'b000, 1'b0};
        rows[13] = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[14] = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b000, 1'b0};
        rows[15] = '{16, 30, 6, 1'b0, 16, 30, 6, 3'b001, 1'b1};
        rows[16] = '{16, 30, 6, 1'b1, 0, 0, 0, 3'b001, 1'b0};

        bus.en      = 1'b0;
        bus.signal  = 1'b0;
        bus2.en     = 1'b0;
        bus2.signal = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then a long idle stretch with no activity.
        @(negedge clk);
        chk("reset pins", int'({bus.S0, bus.S1, bus.S2, bus.S3}), 0);
        chk("reset color", int'(bus.color), 0);
        chk("reset counts", int'(bus.count_r) + int'(bus.count_b) + int'(bus.count_g), 0);
        chk("reset pulses", int'({bus.frame_done, bus.color_change}), 0);
        quiet = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.frame_done || bus.color_change || bus.color != 3'b000 ||
                {bus.S0, bus.S1, bus.S2, bus.S3} != 4'b0000) quiet = 0;
        end
        chk("idle quiet", int'(quiet), 1);

        // Enable and walk the frame table: red commit, swap to blue, none, alternating.
        bus.en = 1'b1;
        @(negedge clk);
        chk("enable pins", int'({bus.S0, bus.S1, bus.S2, bus.S3}), 4'b0100);
        for (int r = 0; r <= 12; r++) run_frame(r);

        // Abort during the blue count window.
        for (int i = 1; i <= PH + S + 100; i++) begin
            @(negedge clk);
            ph = i / PH;
            j  = i % PH;
            bus.signal = pat(j, (ph == 0) ? 5 : 30, 1'b0, S);
        end
        bus.en = 1'b0;
        @(negedge clk);
        bus.signal = 1'b0;
        chk("abort scale", int'({bus.S0, bus.S1}), 0);
        chk("abort count_r", int'(bus.count_r), 5);
        chk("abort count_b", int'(bus.count_b), 24);
        chk("abort count_g", int'(bus.count_g), 10);
        chk("abort color", int'(bus.color), 0);
        quiet = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame_done || bus.color_change || {bus.S0, bus.S1} != 2'b00) quiet = 0;
        end
        chk("abort quiet", int'(quiet), 1);

        // Re-enable: fresh frame from red, debounce restarted.
        bus.en = 1'b1;
        @(negedge clk);
        chk("reenable pins", int'({bus.S0, bus.S1, bus.S2, bus.S3}), 4'b0100);
        for (int r = 13; r <= 16; r++) run_frame(r);

        // Reset landing on the green store cycle suppresses the pending pulse.
        for (int i = 1; i < L; i++) begin
            @(negedge clk);
            ph = i / PH;
            j  = i % PH;
            bus.signal = pat(j, (ph == 0) ? 16 : (ph == 1) ? 30 : 6, 1'b0, S);
        end
        rst = 1'b1;
        @(negedge clk);
        bus.signal = 1'b0;
        chk("midrst frame_done", int'(bus.frame_done), 0);
        chk("midrst color_change", int'(bus.color_change), 0);
        chk("midrst color", int'(bus.color), 0);
        chk("midrst count_r", int'(bus.count_r), 0);
        chk("midrst pins", int'({bus.S0, bus.S1, bus.S2, bus.S3}), 0);
        bus.en = 1'b0;
        rst    = 1'b0;

        // Saturation: 40 red edges into a 4-bit counter.
        @(negedge clk);
        bus2.en = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= L2; i++) begin
            @(negedge clk);
            ph = i / PH2;
            j  = i % PH2;
            bus2.signal = (i < L2 && ph == 0) ? pat(j, 40, 1'b0, S2C) : 1'b0;
        end
        chk("sat frame_done", int'(bus2.frame_done), 1);
        chk("sat count_r", int'(bus2.count_r), 15);
        chk("sat count_b", int'(bus2.count_b), 0);
        chk("sat count_g", int'(bus2.count_g), 0);

        // Window boundary: blue edge lands in STORE (dropped), green edge on last count cycle (kept).
        for (int i = 1; i <= L2; i++) begin
            @(negedge clk);
            ph = i / PH2;
            j  = i % PH2;
            bus2.signal = (i < L2) && ((ph == 1 && j == PH2 - 3) || (ph == 2 && j == PH2 - 4));
        end
        chk("edge frame_done", int'(bus2.frame_done), 1);
        chk("edge count_r", int'(bus2.count_r), 0);
        chk("edge store_drop count_b", int'(bus2.count_b), 0);
        chk("edge last_cycle count_g", int'(bus2.count_g), 1);
        bus2.en = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
